// File: rtl/ecg_filter_pkg.sv
// Shared definitions for the ECG filter stages: default widths, FSM
// encoding and saturation bounds.
package ecg_filter_pkg;

    localparam int DEF_W    = 20;
    localparam int DEF_FRAC = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIFF = 2'd1,
        S_UPD  = 2'd2
    } hpf_state_t;

    localparam logic signed [DEF_W-1:0] SAT_MAX = {1'b0, {(DEF_W-1){1'b1}}};
    localparam logic signed [DEF_W-1:0] SAT_MIN = {1'b1, {(DEF_W-1){1'b0}}};

endpackage

// File: rtl/ecg_highpass_filter_if.sv
// Sample-side bundle of the high-pass stage: strobe, cutoff, input sample
// and the filtered output with its status flags.
interface ecg_highpass_filter_if #(
    parameter int W = ecg_filter_pkg::DEF_W
);
    logic                clk_in;
    logic [3:0]          k;
    logic signed [W-1:0] Vin;
    logic signed [W-1:0] Vout;
    logic                vout_valid;
    logic                primed;
    logic                overrun;

    modport master (
        output clk_in, k, Vin,
        input  Vout, vout_valid, primed, overrun
    );

    modport slave (
        input  clk_in, k, Vin,
        output Vout, vout_valid, primed, overrun
    );
endinterface

// File: rtl/ecg_strobe_edge.sv
// Rising-edge detector for a slow strobe already in the system clock domain.
module ecg_strobe_edge (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic rise
);
    logic strobe_old;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_old <= 1'b0;
        end else begin
            strobe_old <= strobe;
        end
    end

    assign rise = strobe & ~strobe_old;
endmodule

// File: rtl/ecg_highpass_filter.sv
// Single-pole IIR high-pass: Vout = Vin - baseline, baseline tracks Vin with
// time constant ~2^k samples. Define HPF_SATURATE_EN to clamp instead of wrap.
module ecg_highpass_filter
    import ecg_filter_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int FRAC = DEF_FRAC
) (
    input  logic                  qzt_clk,
    input  logic                  reset,
    ecg_highpass_filter_if.slave  bus
);
    localparam int AW = W + FRAC + 1;

    hpf_state_t           state, state_nxt;
    logic                 rise;
    logic                 latch_en, calc_en, upd_en, drop;

    logic signed [W-1:0]  x;
    logic [3:0]           ks;
    logic signed [W:0]    diff_r;
    logic signed [AW-1:0] delta_r;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] x_ext;
    logic signed [W:0]    bl;
    logic signed [W-1:0]  vout_r;
    logic                 valid_r, primed_r, overrun_r;

    function automatic logic signed [W-1:0] fit(input logic signed [W:0] d);
`ifdef HPF_SATURATE_EN
        if (d > W'(SAT_MAX))      return SAT_MAX;
        else if (d < W'(SAT_MIN)) return SAT_MIN;
        else                      return W'(d);
`else
        return W'(d);
`endif
    endfunction

    ecg_strobe_edge u_edge (
        .clk    (qzt_clk),
        .rst    (reset),
        .strobe (bus.clk_in),
        .rise   (rise)
    );

    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (rise) state_nxt = S_DIFF;
            S_DIFF:  state_nxt = S_UPD;
            S_UPD:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        latch_en = (state == S_IDLE) && rise;
        calc_en  = (state == S_DIFF);
        upd_en   = (state == S_UPD);
        drop     = (state != S_IDLE) && rise;
    end

    // Baseline integer part and the current sample on the accumulator grid
    assign bl    = (W+1)'(acc >>> FRAC);
    assign x_ext = $signed({{(AW-W){x[W-1]}}, x}) <<< FRAC;

    // Capture and difference stages: sample data only, no reset needed
    always_ff @(posedge qzt_clk) begin
        if (latch_en) begin
            x  <= bus.Vin;
            ks <= bus.k;
        end
        if (calc_en) begin
            diff_r  <= $signed({x[W-1], x}) - bl;
            delta_r <= (x_ext - acc) >>> ks;
        end
    end

    // Update stage: first sample seeds the baseline, later ones integrate
    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            vout_r    <= '0;
            valid_r   <= 1'b0;
            primed_r  <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            valid_r <= upd_en;
            if (drop) overrun_r <= 1'b1;
            if (upd_en) begin
                if (!primed_r) begin
                    acc      <= x_ext;
                    vout_r   <= '0;
                    primed_r <= 1'b1;
                end else begin
                    acc    <= acc + delta_r;
                    vout_r <= fit(diff_r);
                end
            end
        end
    end

    assign bus.Vout       = vout_r;
    assign bus.vout_valid = valid_r;
    assign bus.primed     = primed_r;
    assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_ecg_highpass_filter.sv
// Scoreboard bench for ecg_highpass_filter: stimulus pushes expected Vout,
// an independent monitor pops and compares on every vout_valid.
module tb_ecg_highpass_filter;
    logic qzt_clk = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_q[$];
    int   n_valid = 0;

    ecg_highpass_filter_if #(.W(20)) bus ();

    ecg_highpass_filter dut (
        .qzt_clk (qzt_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 qzt_clk = ~qzt_clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge qzt_clk) begin
        #1;
        if (bus.vout_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", int'($signed(bus.Vout)), 99999999);
            end else begin
                check("vout", int'($signed(bus.Vout)), exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge qzt_clk);
        reset      = 1'b1;
        bus.clk_in = 1'b0;
        repeat (2) @(negedge qzt_clk);
        reset = 1'b0;
    endtask

    task automatic strobe(input int vin, input int kk, input int exp);
        @(negedge qzt_clk);
        bus.Vin    = 20'(vin);
        bus.k      = 4'(kk);
        bus.clk_in = 1'b1;
        exp_q.push_back(exp);
        @(posedge qzt_clk);
        @(negedge qzt_clk);
        bus.clk_in = 1'b0;
        @(posedge qzt_clk);
        #1 check("valid_early", int'(bus.vout_valid), 0);
        @(posedge qzt_clk);
        #1 check("valid_latency3", int'(bus.vout_valid), 1);
        repeat (2) @(posedge qzt_clk);
    endtask

    initial begin
        int sat_exp;
        int nv;
        bus.clk_in = 1'b0;
        bus.k      = 4'd0;
        bus.Vin    = '0;
        repeat (2) @(posedge qzt_clk);
        #1;
        check("rst_vout",    int'($signed(bus.Vout)), 0);
        check("rst_valid",   int'(bus.vout_valid), 0);
        check("rst_primed",  int'(bus.primed), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        @(negedge qzt_clk);
        reset = 1'b0;

        // Constant input: baseline equals input, output stays at zero
        strobe(1000, 4, 0);
        check("primed_after_first", int'(bus.primed), 1);
        for (int i = 0; i < 9; i++) strobe(1000, 4, 0);

        // Step response with k=1: difference halves each sample
        do_reset();
        strobe(0, 1, 0);
        strobe(1000, 1, 1000);
        strobe(1000, 1, 500);
        strobe(1000, 1, 250);
        strobe(1000, 1, 125);
        strobe(1000, 1, 63);
        strobe(1000, 1, 32);
        strobe(1000, 1, 16);

        // k=0 gives the first difference
        do_reset();
        strobe(0, 0, 0);
        strobe(100, 0, 100);
        strobe(300, 0, 200);
        strobe(250, 0, -50);

        // Full-scale swing: saturate or wrap
`ifdef HPF_SATURATE_EN
        sat_exp = 524287;
`else
        sat_exp = -1;
`endif
        do_reset();
        strobe(-524288, 0, 0);
        strobe(524287, 0, sat_exp);

        // Overrun: second rising edge while busy is dropped
        do_reset();
        strobe(5, 0, 0);
        check("overrun_clear", int'(bus.overrun), 0);
        nv = n_valid;
        @(negedge qzt_clk);
        bus.Vin = 20'd7; bus.k = 4'd0; bus.clk_in = 1'b1;
        exp_q.push_back(2);
        @(negedge qzt_clk);
        bus.clk_in = 1'b0;
        @(negedge qzt_clk);
        bus.Vin = 20'd99; bus.clk_in = 1'b1;
        @(negedge qzt_clk);
        bus.clk_in = 1'b0;
        repeat (4) @(posedge qzt_clk);
        #1;
        check("overrun_set", int'(bus.overrun), 1);
        check("overrun_one_pulse", n_valid - nv, 1);
        strobe(10, 0, 3);
        check("overrun_sticky", int'(bus.overrun), 1);

        // Reset while in S_DIFF aborts without a valid pulse
        @(negedge qzt_clk);
        bus.Vin = 20'd50; bus.k = 4'd0; bus.clk_in = 1'b1;
        @(posedge qzt_clk);
        #1;
        reset      = 1'b1;
        bus.clk_in = 1'b0;
        nv = n_valid;
        repeat (4) @(posedge qzt_clk);
        #2;
        check("abort_no_valid", n_valid - nv, 0);
        check("abort_vout",     int'($signed(bus.Vout)), 0);
        check("abort_primed",   int'(bus.primed), 0);
        check("abort_overrun",  int'(bus.overrun), 0);
        @(negedge qzt_clk);
        reset = 1'b0;
        strobe(77, 2, 0);
        check("reprimed", int'(bus.primed), 1);

        repeat (5) @(posedge qzt_clk);
        #2;
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
